// File: rtl/decode_sequencer.sv
// Decode-stage sequencer: immediate-word squashing, load-use bubble and interrupt entry.
// Latency: outputs are combinational from registered sequence state plus current inputs.
// Backpressure: stall_pc/hold_fd freeze fetch; an immediate fetch bubble simply holds IMM.
module decode_sequencer #(
    parameter logic [15:0] IMM_MASK     = 16'h0000,
    parameter logic [15:0] RS_MASK      = 16'hFFFF,
    parameter logic [15:0] RT_MASK      = 16'hFFFF,
    parameter int unsigned DRAIN_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] instruction,
    input  logic        instr_valid,
    input  logic        ex_memr,
    input  logic        ex_regwrite,
    input  logic [2:0]  ex_dest,
    input  logic        int_req,
    output logic        force_nop,
    output logic        imm_phase,
    output logic        stall_pc,
    output logic        hold_fd,
    output logic        int_taken,
    output logic        push_pc,
    output logic        load_vec,
    output logic        int_ack
);

    typedef enum logic [2:0] {
        RUN       = 3'd0,
        IMM       = 3'd1,
        INT_DRAIN = 3'd2,
        INT_PUSH  = 3'd3,
        INT_VEC   = 3'd4
    } seqState_t;

    typedef struct packed {
        logic forceNop;
        logic immPhase;
        logic stallPc;
        logic holdFd;
        logic intTaken;
        logic pushPc;
        logic loadVec;
        logic intAck;
    } seqCtrl_t;

    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

    seqState_t  state;
    seqState_t  nextState;
    logic       pending;
    logic       pendingNext;
    logic [3:0] drainCnt;
    logic [3:0] drainCntNext;
    seqCtrl_t   ctrl;
    seqCtrl_t   ctrlGated;

    logic [3:0] opcode;
    logic [2:0] rsrc1;
    logic [2:0] rsrc2;
    logic       loadUse;
    logic       twoWord;

    assign opcode = instruction[15:12];
    assign rsrc1  = instruction[11:9];
    assign rsrc2  = instruction[8:6];

    assign loadUse = instr_valid & ex_memr & ex_regwrite &
                     ((RS_MASK[opcode] & (ex_dest == rsrc1)) |
                      (RT_MASK[opcode] & (ex_dest == rsrc2)));
    assign twoWord = instr_valid & IMM_MASK[opcode];

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= RUN;
            pending  <= 1'b0;
            drainCnt <= 4'd0;
        end else begin
            state    <= nextState;
            pending  <= pendingNext;
            drainCnt <= drainCntNext;
        end
    end

    always_comb begin
        nextState    = state;
        drainCntNext = drainCnt;
        ctrl         = '0;
        // Requests during the sequence fold into the one being serviced.
        pendingNext  = (state == INT_VEC) ? 1'b0 : (pending | int_req);

        case (state)
            RUN: begin
                if (pending) begin
                    ctrl.intTaken = 1'b1;
                    ctrl.forceNop = 1'b1;
                    ctrl.stallPc  = 1'b1;
                    nextState     = INT_DRAIN;
                    drainCntNext  = DRAIN_LOAD;
                end else if (loadUse) begin
                    ctrl.forceNop = 1'b1;
                    ctrl.stallPc  = 1'b1;
                    ctrl.holdFd   = 1'b1;
                end else if (twoWord) begin
                    nextState = IMM;
                end
            end
            IMM: begin
                ctrl.immPhase = 1'b1;
                ctrl.forceNop = 1'b1;
                if (instr_valid) begin
                    nextState = RUN;
                end
            end
            INT_DRAIN: begin
                ctrl.forceNop = 1'b1;
                ctrl.stallPc  = 1'b1;
                if (drainCnt == 4'd0) begin
                    nextState = INT_PUSH;
                end else begin
                    drainCntNext = drainCnt - 4'd1;
                end
            end
            INT_PUSH: begin
                ctrl.pushPc   = 1'b1;
                ctrl.forceNop = 1'b1;
                ctrl.stallPc  = 1'b1;
                nextState     = INT_VEC;
            end
            INT_VEC: begin
                ctrl.loadVec  = 1'b1;
                ctrl.intAck   = 1'b1;
                ctrl.forceNop = 1'b1;
                nextState     = RUN;
            end
            default: begin
                nextState = RUN;
            end
        endcase
    end

    // Quiet all controls while reset is low so a reset landing mid-sequence emits no partial push/vector pulse.
    assign ctrlGated = reset ? ctrl : '0;

    assign force_nop = ctrlGated.forceNop;
    assign imm_phase = ctrlGated.immPhase;
    assign stall_pc  = ctrlGated.stallPc;
    assign hold_fd   = ctrlGated.holdFd;
    assign int_taken = ctrlGated.intTaken;
    assign push_pc   = ctrlGated.pushPc;
    assign load_vec  = ctrlGated.loadVec;
    assign int_ack   = ctrlGated.intAck;

endmodule

// File: tb/tb_decode_sequencer.sv
// Bench for decode_sequencer: directed vector table, then random traffic against a sequence-position model.
module tb_decode_sequencer;

    localparam logic [15:0] TB_IMM   = 16'h8010;
    localparam logic [15:0] TB_RS    = 16'hFEFF;
    localparam logic [15:0] TB_RT    = 16'hFFBF;
    localparam int          TB_DRAIN = 2;

    localparam logic [7:0] FN = 8'h80;
    localparam logic [7:0] IM = 8'h40;
    localparam logic [7:0] SP = 8'h20;
    localparam logic [7:0] HF = 8'h10;
    localparam logic [7:0] IT = 8'h08;
    localparam logic [7:0] PP = 8'h04;
    localparam logic [7:0] LV = 8'h02;
    localparam logic [7:0] AK = 8'h01;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] instruction;
    logic        instr_valid;
    logic        ex_memr;
    logic        ex_regwrite;
    logic [2:0]  ex_dest;
    logic        int_req;
    logic        force_nop, imm_phase, stall_pc, hold_fd;
    logic        int_taken, push_pc, load_vec, int_ack;
    logic [7:0]  dutOut;

    always #5 clk = ~clk;

    decode_sequencer #(
        .IMM_MASK    (TB_IMM),
        .RS_MASK     (TB_RS),
        .RT_MASK     (TB_RT),
        .DRAIN_CYCLES(TB_DRAIN)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .instruction(instruction),
        .instr_valid(instr_valid),
        .ex_memr    (ex_memr),
        .ex_regwrite(ex_regwrite),
        .ex_dest    (ex_dest),
        .int_req    (int_req),
        .force_nop  (force_nop),
        .imm_phase  (imm_phase),
        .stall_pc   (stall_pc),
        .hold_fd    (hold_fd),
        .int_taken  (int_taken),
        .push_pc    (push_pc),
        .load_vec   (load_vec),
        .int_ack    (int_ack)
    );

    assign dutOut = {force_nop, imm_phase, stall_pc, hold_fd, int_taken, push_pc, load_vec, int_ack};

    int checks = 0;
    int errors = 0;

    // Model: cycles elapsed since acceptance (0 = none), immediate flag, pending flag.
    int mSeq  = 0;
    bit mImm  = 1'b0;
    bit mPend = 1'b0;

    typedef struct {
        string       name;
        logic        rst;
        logic [15:0] ins;
        logic        vld;
        logic        memr;
        logic        regw;
        logic [2:0]  dest;
        logic        irq;
        logic [7:0]  exp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(string n, logic rst, logic [15:0] ins, logic vld, logic memr,
                               logic regw, logic [2:0] dest, logic irq, logic [7:0] exp);
        vec_t r;
        r.name = n; r.rst = rst; r.ins = ins; r.vld = vld; r.memr = memr;
        r.regw = regw; r.dest = dest; r.irq = irq; r.exp = exp;
        return r;
    endfunction

    function automatic bit hazardOf(logic [15:0] ins, logic vld, logic memr, logic regw, logic [2:0] dest);
        int op;
        bit rsHit, rtHit;
        op    = int'(ins[15:12]);
        rsHit = TB_RS[op] && (dest == ins[11:9]);
        rtHit = TB_RT[op] && (dest == ins[8:6]);
        return vld && memr && regw && (rsHit || rtHit);
    endfunction

    function automatic logic [7:0] modelOut(logic rst, logic [15:0] ins, logic vld, logic memr,
                                            logic regw, logic [2:0] dest);
        if (!rst)                          return 8'h00;
        if (mSeq >= 1 && mSeq <= TB_DRAIN) return FN | SP;
        if (mSeq == TB_DRAIN + 1)          return FN | SP | PP;
        if (mSeq == TB_DRAIN + 2)          return FN | LV | AK;
        if (mImm)                          return FN | IM;
        if (mPend)                         return FN | SP | IT;
        if (hazardOf(ins, vld, memr, regw, dest)) return FN | SP | HF;
        return 8'h00;
    endfunction

    task automatic modelEdge(logic rst, logic [15:0] ins, logic vld, logic memr,
                             logic regw, logic [2:0] dest, logic irq);
        bit newPend;
        if (!rst) begin
            mSeq = 0; mImm = 1'b0; mPend = 1'b0;
        end else begin
            newPend = (mSeq == TB_DRAIN + 2) ? 1'b0 : (mPend || irq);
            if (mSeq > 0)
                mSeq = (mSeq == TB_DRAIN + 2) ? 0 : mSeq + 1;
            else if (mImm)
                mImm = !vld;
            else if (mPend)
                mSeq = 1;
            else if (!hazardOf(ins, vld, memr, regw, dest) && vld && TB_IMM[int'(ins[15:12])])
                mImm = 1'b1;
            mPend = newPend;
        end
    endtask

    task automatic applyCycle(string name, logic rst, logic [15:0] ins, logic vld, logic memr,
                              logic regw, logic [2:0] dest, logic irq, bit useExp, logic [7:0] exp);
        logic [7:0] want;
        @(negedge clk);
        reset = rst; instruction = ins; instr_valid = vld; ex_memr = memr;
        ex_regwrite = regw; ex_dest = dest; int_req = irq;
        #1;
        want = useExp ? exp : modelOut(rst, ins, vld, memr, regw, dest);
        checks++;
        if (dutOut !== want) begin
            errors++;
            $display("FAIL %s: outputs got %h want %h (model seq=%0d imm=%0d pend=%0d)",
                     name, dutOut, want, mSeq, mImm, mPend);
        end
        @(posedge clk);
        modelEdge(rst, ins, vld, memr, regw, dest, irq);
    endtask

    initial begin
        reset = 1'b0; instruction = 16'h0; instr_valid = 1'b0; ex_memr = 1'b0;
        ex_regwrite = 1'b0; ex_dest = 3'd0; int_req = 1'b1;
        @(posedge clk);
        modelEdge(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);

        vecs.push_back(v("rst_hold0",   0, 16'h2600, 1, 1, 1, 3'd3, 1, 8'h00));
        vecs.push_back(v("rst_hold1",   0, 16'h0000, 0, 0, 0, 3'd0, 1, 8'h00));
        vecs.push_back(v("rst_rel",     1, 16'h0000, 0, 0, 0, 3'd0, 0, 8'h00));
        vecs.push_back(v("rst_nopend",  1, 16'h0000, 0, 0, 0, 3'd0, 0, 8'h00));
        vecs.push_back(v("imm_op",      1, 16'h4200, 1, 0, 0, 3'd0, 0, 8'h00));
        vecs.push_back(v("imm_word",    1, 16'h1234, 1, 0, 0, 3'd0, 0, FN | IM));
        vecs.push_back(v("imm_back",    1, 16'h1000, 1, 0, 0, 3'd0, 0, 8'h00));
        vecs.push_back(v("imm_op2",     1, 16'h4000, 1, 0, 0, 3'd0, 0, 8'h00));
        vecs.push_back(v("imm_bubble",  1, 16'h4000, 0, 0, 0, 3'd0, 0, FN | IM));
        vecs.push_back(v("imm_word2",   1, 16'h5555, 1, 0, 0, 3'd0, 0, FN | IM));
        vecs.push_back(v("imm_run",     1, 16'h0000, 0, 0, 0, 3'd0, 0, 8'h00));
        vecs.push_back(v("lu_rs",       1, 16'h2600, 1, 1, 1, 3'd3, 0, FN | SP | HF));
        vecs.push_back(v("lu_clear",    1, 16'h2600, 1, 0, 1, 3'd3, 0, 8'h00));
        vecs.push_back(v("lu_dest5",    1, 16'h2600, 1, 1, 1, 3'd5, 0, 8'h00));
        vecs.push_back(v("lu_rt",       1, 16'h2140, 1, 1, 1, 3'd5, 0, FN | SP | HF));
        vecs.push_back(v("lu_rtmask",   1, 16'h6140, 1, 1, 1, 3'd5, 0, 8'h00));
        vecs.push_back(v("lu_noregw",   1, 16'h2600, 1, 1, 0, 3'd3, 0, 8'h00));
        vecs.push_back(v("lu_novld",    1, 16'h2600, 0, 1, 1, 3'd3, 0, 8'h00));
        vecs.push_back(v("int_req",     1, 16'h0000, 0, 0, 0, 3'd0, 1, 8'h00));
        vecs.push_back(v("int_take",    1, 16'h0000, 0, 0, 0, 3'd0, 0, FN | SP | IT));
        vecs.push_back(v("int_drain0",  1, 16'h0000, 0, 0, 0, 3'd0, 0, FN | SP));
        vecs.push_back(v("int_drain1",  1, 16'h0000, 0, 0, 0, 3'd0, 0, FN | SP));
        vecs.push_back(v("int_push",    1, 16'h0000, 0, 0, 0, 3'd0, 0, FN | SP | PP));
        vecs.push_back(v("int_vec",     1, 16'h0000, 0, 0, 0, 3'd0, 0, FN | LV | AK));
        vecs.push_back(v("int_done",    1, 16'h0000, 0, 0, 0, 3'd0, 0, 8'h00));
        vecs.push_back(v("immint_op",   1, 16'h4200, 1, 0, 0, 3'd0, 1, 8'h00));
        vecs.push_back(v("immint_word", 1, 16'h1234, 1, 0, 0, 3'd0, 0, FN | IM));
        vecs.push_back(v("immint_take", 1, 16'h0000, 0, 0, 0, 3'd0, 0, FN | SP | IT));
        vecs.push_back(v("immint_dr0",  1, 16'h0000, 0, 0, 0, 3'd0, 0, FN | SP));
        vecs.push_back(v("immint_dr1",  1, 16'h0000, 0, 0, 0, 3'd0, 0, FN | SP));
        vecs.push_back(v("immint_push", 1, 16'h0000, 0, 0, 0, 3'd0, 0, FN | SP | PP));
        vecs.push_back(v("immint_vec",  1, 16'h0000, 0, 0, 0, 3'd0, 0, FN | LV | AK));
        vecs.push_back(v("immint_done", 1, 16'h0000, 0, 0, 0, 3'd0, 0, 8'h00));
        vecs.push_back(v("hz_req",      1, 16'h0000, 0, 0, 0, 3'd0, 1, 8'h00));
        vecs.push_back(v("hz_int_wins", 1, 16'h2600, 1, 1, 1, 3'd3, 0, FN | SP | IT));
        vecs.push_back(v("hz_dr0",      1, 16'h0000, 0, 0, 0, 3'd0, 0, FN | SP));
        vecs.push_back(v("hz_dr1",      1, 16'h0000, 0, 0, 0, 3'd0, 0, FN | SP));
        vecs.push_back(v("rst_in_push", 0, 16'h0000, 0, 0, 0, 3'd0, 0, 8'h00));
        vecs.push_back(v("rst_after0",  1, 16'h0000, 0, 0, 0, 3'd0, 0, 8'h00));
        vecs.push_back(v("rst_after1",  1, 16'h0000, 0, 0, 0, 3'd0, 0, 8'h00));
        vecs.push_back(v("lu_immop",    1, 16'h4600, 1, 1, 1, 3'd3, 0, FN | SP | HF));
        vecs.push_back(v("lu_immop_go", 1, 16'h4600, 1, 0, 0, 3'd3, 0, 8'h00));
        vecs.push_back(v("lu_imm_bub",  1, 16'h0000, 0, 0, 0, 3'd0, 0, FN | IM));
        vecs.push_back(v("lu_imm_word", 1, 16'h1111, 1, 0, 0, 3'd0, 0, FN | IM));
        vecs.push_back(v("lu_imm_done", 1, 16'h0000, 0, 0, 0, 3'd0, 0, 8'h00));

        foreach (vecs[i])
            applyCycle(vecs[i].name, vecs[i].rst, vecs[i].ins, vecs[i].vld, vecs[i].memr,
                       vecs[i].regw, vecs[i].dest, vecs[i].irq, 1'b1, vecs[i].exp);

        for (int n = 0; n < 3000; n++) begin
            logic        rRst, rVld, rMemr, rRegw, rIrq;
            logic [15:0] rIns;
            logic [2:0]  rDest;
            rRst  = ($urandom_range(99) != 0);
            rIrq  = ($urandom_range(15) == 0);
            rIns  = 16'($urandom_range(65535));
            rVld  = ($urandom_range(3) != 0);
            rMemr = 1'($urandom_range(1));
            rRegw = 1'($urandom_range(1));
            rDest = 3'($urandom_range(7));
            applyCycle("random", rRst, rIns, rVld, rMemr, rRegw, rDest, rIrq, 1'b0, 8'h00);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_sequencer.md
Name: decode_sequencer

Overview:
- Sequencing controller for the 16-bit pipeline decode stage.
- Tracks two-word (opcode + immediate) instructions so the immediate word is decoded as NOP.
- Detects load-use hazards against the EX stage and inserts one bubble.
- Sequences interrupt entry (drain, push PC, vector load) and drives the control unit's opcode-override and the fetch/PC stall controls.

Parameters:
- IMM_MASK, 16'h0000, bit n set = opcode n is followed by a 16-bit immediate word.
- RS_MASK, 16'hFFFF, bit n set = opcode n reads Rsrc1 (instruction[11:9]).
- RT_MASK, 16'hFFFF, bit n set = opcode n reads Rsrc2 (instruction[8:6]).
- DRAIN_CYCLES, 2, NOP cycles inserted after interrupt acceptance (1..15).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- instruction  in  16  word currently in the IF/ID register.
- instr_valid  in  1  instruction holds a real fetched word.
- ex_memr  in  1  EX-stage instruction reads memory.
- ex_regwrite  in  1  EX-stage instruction writes the register file.
- ex_dest  in  3  EX-stage destination register.
- int_req  in  1  external interrupt request, level, sampled each clock.
- force_nop  out  1  control unit must decode opcode 4'b0000.
- imm_phase  out  1  current IF/ID word is an immediate.
- stall_pc  out  1  hold PC.
- hold_fd  out  1  hold IF/ID register.
- int_taken  out  1  pulse; fetch saves the decode-stage PC as return address.
- push_pc  out  1  pulse; push the saved return address onto the stack.
- load_vec  out  1  pulse; PC loads the interrupt vector.
- int_ack  out  1  pulse, coincident with load_vec.

Behaviour:
- opcode = instruction[15:12].
- All outputs are Moore/combinational from state plus current inputs; no output latency beyond that.
- Reset (reset==0 at a clock edge): state=RUN, pending=0, drain counter=0. All outputs are 0 while in RUN with instr_valid=0 and no hazard.
- pending: set at any edge where int_req=1. Cleared only in INT_VEC. Requests arriving while pending or during the sequence merge into it; there is no queueing.
- State RUN:
  - Priority 1, accept interrupt: pending=1 and the current word is an opcode (state RUN, not IMM).
    - Outputs: int_taken=1, force_nop=1, stall_pc=1, hold_fd=0.
    - Next state INT_DRAIN, counter=DRAIN_CYCLES-1.
    - The squashed instruction re-executes after the ISR.
  - Priority 2, load-use hazard: instr_valid & ex_memr & ex_regwrite & ((RS_MASK[opcode] & ex_dest==instruction[11:9]) | (RT_MASK[opcode] & ex_dest==instruction[8:6])).
    - Outputs: force_nop=1, stall_pc=1, hold_fd=1.
    - Stay in RUN. The next cycle sees a bubble in EX, so the stall lasts exactly 1 cycle.
  - Priority 3, two-word instruction: instr_valid & IMM_MASK[opcode]. Normal decode; next state IMM.
  - Otherwise: normal decode; no outputs asserted.
- State IMM:
  - Outputs: imm_phase=1, force_nop=1. Interrupts are not accepted and there is no hazard check.
  - If instr_valid=1, next state RUN; if instr_valid=0 (fetch bubble), stay in IMM.
- State INT_DRAIN:
  - Outputs: force_nop=1, stall_pc=1.
  - Counter decrements each cycle; when counter==0, next state INT_PUSH.
- State INT_PUSH: push_pc=1, force_nop=1, stall_pc=1; next state INT_VEC.
- State INT_VEC: load_vec=1, int_ack=1, force_nop=1; pending cleared; next state RUN.
- Interrupt sequence length from acceptance to first ISR decode: DRAIN_CYCLES+3 cycles.
- Reset asserted mid-sequence (any state): returns to RUN next edge. Pending is dropped and no partial push/vector pulses occur afterwards.
- Masks are indexed by opcode, so all 16 opcodes are covered. Register compare is a 3-bit equality; R0 is not special.

Test Plan:
- Reset: hold reset=0 for 2 cycles with int_req=1 -> all outputs 0, state RUN. After release with int_req=0, pending=0 and no int_taken.
- Immediate: IMM_MASK bit 4 set; instruction=16'h4200 then 16'h1234 (valid) -> cycle 1 all outputs 0. Cycle 2 imm_phase=1, force_nop=1. Cycle 3 back to RUN.
- Load-use: ex_memr=1, ex_regwrite=1, ex_dest=3, instruction=16'h2600 (Rsrc1=3) -> one cycle of stall_pc=hold_fd=force_nop=1. Next cycle (ex_memr=0) no stall. ex_dest=5 -> no stall.
- Interrupt: pulse int_req for 1 cycle during RUN with DRAIN_CYCLES=2 -> int_taken, then 2 drain cycles, then push_pc, then load_vec with int_ack. Total 5 cycles, then RUN with pending=0.
- Interrupt during IMM: int_req while an immediate is pending -> IMM cycle completes with force_nop=1 and no int_taken. int_taken occurs in the following RUN cycle.
- Hazard plus pending interrupt in the same cycle -> int_taken=1, hold_fd=0 (interrupt wins). Reset asserted in INT_PUSH -> push_pc and load_vec never asserted.
